// File: rtl/dac_seg_encoder_if.sv
// Sample stream handshake into the DAC segment encoder.
//   s_valid : producer has a sample on s_data
//   s_ready : encoder buffer can accept a sample this cycle
//   s_data  : unsigned DAC code, DATA_W bits
// master = sample producer, slave = dac_seg_encoder.
interface dac_seg_encoder_if #(
    parameter int DATA_W = 10
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/dac_seg_encoder.sv
// Segmented current-steering DAC code encoder.
// Buffers incoming codes in a small FIFO and, on every divider tick, loads a
// new code chosen by mode (stream / ramp / hold / midscale). The code is
// split into BIN_W binary-weighted LSBs and a thermometer-coded MSB field,
// each driven together with its exact complement for differential switches.
// Ports:
//   clkin        : sole clock, rising edge
//   pdb          : asynchronous active-low reset (power-down bar)
//   s_bus        : sample handshake (s_valid / s_ready / s_data)
//   mode         : 00 stream, 01 ramp, 10 hold, 11 midscale (sampled at tick)
//   div          : update period minus one, in clkin cycles
//   hold_code    : code loaded in hold mode
//   clr_flags    : clears the sticky underflow flag
//   datainbin(b) : binary LSBs and complement
//   dataintherm(b): thermometer MSBs and complement
//   code_out     : code currently driven
//   update       : one-cycle strobe with each new output code
//   underflow    : sticky, set when a stream tick finds the FIFO empty
//   fifo_level   : current FIFO occupancy
module dac_seg_encoder #(
    parameter  int DATA_W     = 10,
    parameter  int BIN_W      = 7,
    parameter  int FIFO_DEPTH = 8,
    parameter  int DIV_W      = 8,
    localparam int MSB_W      = DATA_W - BIN_W,
    localparam int THERM_W    = (2 ** MSB_W) - 1,
    localparam int AW         = $clog2(FIFO_DEPTH),
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clkin,
    input  logic                pdb,
    dac_seg_encoder_if.slave    s_bus,
    input  logic [1:0]          mode,
    input  logic [DIV_W-1:0]    div,
    input  logic [DATA_W-1:0]   hold_code,
    input  logic                clr_flags,
    output logic [BIN_W-1:0]    datainbin,
    output logic [BIN_W-1:0]    datainbinb,
    output logic [THERM_W-1:0]  dataintherm,
    output logic [THERM_W-1:0]  datainthermb,
    output logic [DATA_W-1:0]   code_out,
    output logic                update,
    output logic                underflow,
    output logic [LVL_W-1:0]    fifo_level
);

    localparam logic [1:0] MODE_STREAM = 2'b00;
    localparam logic [1:0] MODE_RAMP   = 2'b01;
    localparam logic [1:0] MODE_HOLD   = 2'b10;
    localparam logic [DATA_W-1:0] MIDSCALE = DATA_W'(1) << (DATA_W - 1);

    // Thermometer bit i is lit when the MSB field exceeds i.
    function automatic logic [THERM_W-1:0] therm_of(input logic [DATA_W-1:0] code);
        logic [MSB_W-1:0] msb;
        msb = code[DATA_W-1:BIN_W];
        for (int i = 0; i < THERM_W; i++) begin
            therm_of[i] = (32'(msb) > i);
        end
    endfunction

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              run_q;
    logic [DIV_W-1:0]  cnt;
    logic [DATA_W-1:0] ramp_q;
    logic [1:0]        last_mode;

    logic              tick_p0;
    logic              push_p0;
    logic              pop_p0;
    logic              uf_set_p0;
    logic [DATA_W-1:0] code_nxt_p0;

    // run_q keeps s_ready low while pdb is asserted and for the release edge.
    assign s_bus.s_ready = run_q && (fifo_level != LVL_W'(FIFO_DEPTH));
    assign push_p0       = s_bus.s_valid && s_bus.s_ready;
    // ">=" so that lowering div below the running count ticks right away.
    assign tick_p0       = (cnt >= div);

    // ---- stage p0: tick decode and next-code selection ----
    always_comb begin
        code_nxt_p0 = code_out;
        pop_p0      = 1'b0;
        uf_set_p0   = 1'b0;
        if (tick_p0) begin
            unique case (mode)
                MODE_STREAM: begin
                    if (fifo_level != '0) begin
                        pop_p0      = 1'b1;
                        code_nxt_p0 = mem[rd_ptr];
                    end else begin
                        uf_set_p0   = 1'b1;
                    end
                end
                // A ramp restarts from zero whenever the previous tick was not a ramp tick.
                MODE_RAMP: code_nxt_p0 = (last_mode == MODE_RAMP) ? ramp_q : '0;
                MODE_HOLD: code_nxt_p0 = hold_code;
                default:   code_nxt_p0 = MIDSCALE;
            endcase
        end
    end

    always_ff @(posedge clkin) begin
        if (push_p0) begin
            mem[wr_ptr] <= s_bus.s_data;
        end
    end

    // ---- stage p1: registered control and segmented outputs ----
    always_ff @(posedge clkin or negedge pdb) begin
        if (!pdb) begin
            run_q        <= 1'b0;
            cnt          <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            ramp_q       <= '0;
            last_mode    <= MODE_STREAM;
            underflow    <= 1'b0;
            update       <= 1'b0;
            code_out     <= '0;
            datainbin    <= '0;
            datainbinb   <= '1;
            dataintherm  <= '0;
            datainthermb <= '1;
        end else begin
            run_q      <= 1'b1;
            cnt        <= tick_p0 ? '0 : cnt + 1'b1;
            if (push_p0) wr_ptr <= wr_ptr + 1'b1;
            if (pop_p0)  rd_ptr <= rd_ptr + 1'b1;
            fifo_level <= fifo_level + LVL_W'(push_p0) - LVL_W'(pop_p0);
            if (tick_p0) begin
                last_mode <= mode;
                if (mode == MODE_RAMP) ramp_q <= code_nxt_p0 + 1'b1;
            end
            // Set has priority over clear.
            if (uf_set_p0)      underflow <= 1'b1;
            else if (clr_flags) underflow <= 1'b0;
            update       <= tick_p0;
            code_out     <= code_nxt_p0;
            datainbin    <= code_nxt_p0[BIN_W-1:0];
            datainbinb   <= ~code_nxt_p0[BIN_W-1:0];
            dataintherm  <= therm_of(code_nxt_p0);
            datainthermb <= ~therm_of(code_nxt_p0);
        end
    end

endmodule

// File: tb/tb_dac_seg_encoder.sv
// Randomized plus directed bench for dac_seg_encoder at default parameters.
// A reference model (queue FIFO, integer counters) advances once per clock
// and every output is compared on the falling edge.
module tb_dac_seg_encoder;

    localparam int DEPTH = 8;

    logic       clkin = 1'b0;
    logic       pdb;
    logic [1:0] mode;
    logic [7:0] div;
    logic [9:0] hold_code;
    logic       clr_flags;
    logic [6:0] datainbin, datainbinb, dataintherm, datainthermb;
    logic [9:0] code_out;
    logic       update, underflow;
    logic [3:0] fifo_level;

    dac_seg_encoder_if #(.DATA_W(10)) bus ();

    dac_seg_encoder dut (
        .clkin        (clkin),
        .pdb          (pdb),
        .s_bus        (bus),
        .mode         (mode),
        .div          (div),
        .hold_code    (hold_code),
        .clr_flags    (clr_flags),
        .datainbin    (datainbin),
        .datainbinb   (datainbinb),
        .dataintherm  (dataintherm),
        .datainthermb (datainthermb),
        .code_out     (code_out),
        .update       (update),
        .underflow    (underflow),
        .fifo_level   (fifo_level)
    );

    always #5 clkin = ~clkin;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int q[$];
    int m_cnt, m_code, m_ramp, m_last;
    bit m_upd, m_uf, m_run;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        n_checks++;
        if (obs !== 32'(exp)) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_cnt = 0; m_code = 0; m_ramp = 0; m_last = 0;
        m_upd = 0; m_uf = 0; m_run = 0;
    endtask

    // One clock of the behavioural rules, using the inputs applied this cycle.
    task automatic model_step();
        bit tick, rdy, push, uf_set;
        if (!pdb) return;
        tick   = (m_cnt >= int'(div));
        rdy    = m_run && (q.size() != DEPTH);
        push   = bus.s_valid && rdy;
        uf_set = 0;
        if (tick) begin
            case (mode)
                2'd0: if (q.size() > 0) m_code = q.pop_front(); else uf_set = 1;
                2'd1: begin
                    m_code = (m_last == 1) ? m_ramp : 0;
                    m_ramp = (m_code + 1) % 1024;
                end
                2'd2: m_code = int'(hold_code);
                default: m_code = 512;
            endcase
            m_last = int'(mode);
        end
        if (push) q.push_back(int'(bus.s_data));
        if (uf_set) m_uf = 1;
        else if (clr_flags) m_uf = 0;
        m_upd = tick;
        m_cnt = tick ? 0 : m_cnt + 1;
        m_run = 1;
    endtask

    task automatic check_all();
        int therm;
        therm = (1 << (m_code / 128)) - 1;
        chk("code_out",     code_out,     m_code);
        chk("datainbin",    datainbin,    m_code % 128);
        chk("datainbinb",   datainbinb,   127 - (m_code % 128));
        chk("dataintherm",  dataintherm,  therm);
        chk("datainthermb", datainthermb, 127 - therm);
        chk("update",       update,       int'(m_upd));
        chk("underflow",    underflow,    int'(m_uf));
        chk("fifo_level",   fifo_level,   q.size());
        chk("s_ready",      bus.s_ready,  int'(m_run && (q.size() != DEPTH)));
    endtask

    task automatic cycle();
        @(posedge clkin);
        model_step();
        @(negedge clkin);
        check_all();
    endtask

    task automatic push_run(input int n);
        for (int i = 0; i < n; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 10'($urandom_range(0, 1023));
            cycle();
        end
        bus.s_valid = 1'b0;
    endtask

    initial begin
        pdb = 1'b1; mode = 2'd0; div = 8'd0; hold_code = 10'd0; clr_flags = 1'b0;
        bus.s_valid = 1'b0; bus.s_data = 10'd0;
        #2 pdb = 1'b0;
        model_reset();
        #1 check_all();
        repeat (3) cycle();
        pdb = 1'b1;
        cycle();

        // stream at div=0 with the listed edge codes
        mode = 2'd0; div = 8'd0;
        foreach (q[i]) ; // no-op keeps queue untouched
        begin
            int codes[4] = '{10'h000, 10'h07F, 10'h080, 10'h3FF};
            for (int i = 0; i < 4; i++) begin
                bus.s_valid = 1'b1; bus.s_data = 10'(codes[i]);
                cycle();
            end
            bus.s_valid = 1'b0;
        end
        repeat (4) cycle();
        clr_flags = 1'b1; cycle(); clr_flags = 1'b0;

        // underflow at div=3, then clear asserted across underflow ticks
        div = 8'd3;
        repeat (16) cycle();
        clr_flags = 1'b1;
        repeat (8) cycle();
        clr_flags = 1'b0;
        repeat (4) cycle();

        // fill while holding, then drain in stream
        mode = 2'd2; hold_code = 10'h155; div = 8'd0;
        push_run(9);
        cycle();
        mode = 2'd0;
        repeat (12) cycle();

        // full ramp with wrap
        mode = 2'd1; div = 8'd0;
        repeat (1030) cycle();

        // midscale, then hold
        mode = 2'd3; repeat (4) cycle();
        mode = 2'd2; hold_code = 10'h155; repeat (4) cycle();

        // reset mid-operation with five samples buffered
        push_run(5);
        #2 pdb = 1'b0;
        model_reset();
        #1 check_all();
        repeat (2) cycle();
        pdb = 1'b1; mode = 2'd0; div = 8'd2;
        repeat (10) cycle();

        // random operation
        for (int i = 0; i < 3000; i++) begin
            bus.s_valid = 1'($urandom_range(0, 1));
            bus.s_data  = 10'($urandom_range(0, 1023));
            clr_flags   = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) div = 8'($urandom_range(0, 5));
            if ($urandom_range(0, 15) == 0) hold_code = 10'($urandom_range(0, 1023));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dac_seg_encoder.md
DAC_SEG_ENCODER -- requirements
Module: dac_seg_encoder

Interface
REQ-001 SHALL have parameter DATA_W, default 10, DAC code width.
REQ-002 SHALL have parameter BIN_W, default 7, binary-weighted LSB count; THERM_W = 2^(DATA_W-BIN_W)-1 derived, 7 at defaults.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, power of two >= 2; sample buffer depth.
REQ-004 SHALL have parameter DIV_W, default 8, width of update divider.
REQ-005 SHALL have ports: clkin  in  1  sole clock, rising edge.
REQ-006 pdb  in  1  asynchronous active-low reset (power-down bar).
REQ-007 s_valid  in  1  input sample valid.
REQ-008 s_ready  out  1  buffer can accept a sample.
REQ-009 s_data  in  DATA_W  unsigned input code.
REQ-010 mode  in  2  00 stream, 01 ramp, 10 hold, 11 midscale.
REQ-011 div  in  DIV_W  update period minus one, in clkin cycles.
REQ-012 hold_code  in  DATA_W  code driven in hold mode.
REQ-013 clr_flags  in  1  clears underflow flag.
REQ-014 datainbin / datainbinb  out  BIN_W each  binary LSBs and complement.
REQ-015 dataintherm / datainthermb  out  THERM_W each  thermometer MSBs and complement.
REQ-016 code_out  out  DATA_W  code currently driven.
REQ-017 update  out  1  one-cycle strobe, high in the cycle new outputs appear.
REQ-018 underflow  out  1  sticky stream underflow flag.
REQ-019 fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.

Function
REQ-020 Push when s_valid && s_ready; s_ready = (fifo_level != FIFO_DEPTH), from registered state only.
REQ-021 Divider counter cnt counts 0..div; tick when cnt >= div, then cnt returns to 0; div=0 gives a tick every cycle; a div decrease below cnt ticks on the next cycle.
REQ-022 Mode sampled only at tick; changes between ticks have no effect until the next tick.
REQ-023 Stream tick, FIFO non-empty: pop head, load as code. FIFO empty: keep previous code, set underflow.
REQ-024 Ramp tick: load ramp counter, then increment it, wrapping 2^DATA_W-1 -> 0; counter clears to 0 on the first tick after mode enters 01, so first ramp code is 0.
REQ-025 Hold tick: load hold_code. Midscale tick: load 2^(DATA_W-1).
REQ-026 FIFO not popped outside stream mode; pushes continue until full.
REQ-027 Push and pop in the same cycle allowed when not full; level unchanged.
REQ-028 All outputs registered; code, segmented outputs and update change on the same edge, one edge after the tick cycle (latency 1).
REQ-029 datainbin = code[BIN_W-1:0]; dataintherm[i] = 1 iff code[DATA_W-1:BIN_W] > i; each *b output is the exact bitwise complement of its pair in every cycle.
REQ-030 update asserted for exactly one cycle per tick, in all modes, including underflow ticks.
REQ-031 clr_flags clears underflow; simultaneous set and clear: set wins.

Reset
REQ-032 pdb low asynchronously forces: code_out 0, datainbin 0, datainbinb all 1, dataintherm 0, datainthermb all 1, update 0, underflow 0, FIFO empty, fifo_level 0, cnt 0, ramp counter 0.
REQ-033 s_ready SHALL be 0 while pdb low; first tick after release occurs div+1 cycles after the first rising edge with pdb high.
REQ-034 Reset mid-operation discards buffered samples; no stale sample appears after release.

Verification
REQ-035 Defaults, div=0, stream, push 0x000,0x07F,0x080,0x3FF -> four consecutive updates; at 0x3FF bin=7'h7F, therm=7'h7F; at 0x080 bin=0, therm=7'h01.
REQ-036 div=3, stream, FIFO empty -> update every 4 cycles, code held, underflow set; clr_flags with simultaneous underflow tick -> underflow stays 1.
REQ-037 Push 9 samples back-to-back with mode=hold -> s_ready low after 8, fifo_level=8; switch to stream -> samples emerge in order, one per tick.
REQ-038 Ramp, div=0, 1026 ticks -> codes 0..1023, 0, 1; complements checked every cycle.
REQ-039 Midscale tick -> code_out 0x200, therm=7'h0F, bin=0; hold_code=0x155 in hold -> code 0x155.
REQ-040 pdb pulsed low mid-stream with 5 samples buffered -> all outputs at reset values immediately, fifo_level 0, first post-release stream tick flags underflow.
